fb_writer: RTL
==============

Name: fb_writer

Overview:
- Framebuffer write engine: the write-side counterpart to the video adapter, which only reads the ZX-layout screen at 0x4000–0x5AFF.
- Accepts pixel commands (plot, unplot, xor, clear) over a valid/ready handshake.
- Translates (x,y) to Spectrum bitmap addresses and performs read-modify-write on the processor-side memory port (address_a/q_a/data_a/wren_a).
- Lets a test harness or host draw without the Z80 core.

Parameters:
RD_LAT, 2, cycles from address driven (wren=0) to mem_q valid; legal 1..4
BASE_HI, 3'b010, upper 3 address bits of the screen region (0x4000)

Ports:
clk  in  1  system clock (memory clock domain)
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command this cycle
cmd_op  in  2  0=PLOT (set bit), 1=UNPLOT (clear bit), 2=XOR, 3=CLEAR screen
cmd_x  in  8  pixel column 0..255
cmd_y  in  8  pixel row 0..191
cmd_attr  in  8  attribute byte used by CLEAR
mem_addr  out  16  memory address
mem_q  in  8  memory read data
mem_data  out  8  memory write data
mem_wren  out  1  write enable, one cycle per byte
busy  out  1  high while a command is executing
done  out  1  one-cycle pulse when a command completes or is dropped

Behaviour:
- Reset (async, reset_n=0): state IDLE; cmd_ready=1; busy=0; done=0; mem_wren=0; mem_addr=0x0000; mem_data=0x00. Assert and deassert may occur in any state.
- Handshake:
  - Accept when cmd_valid && cmd_ready at a rising edge; all cmd_* are latched then.
  - cmd_ready=1 only in IDLE; busy = !cmd_ready.
- Address map, latched command:
  - Bitmap offset A13 = {y[7:6], y[2:0], y[5:3], x[7:3]}; mem_addr = {BASE_HI, A13}.
  - Bit mask M = 8'h80 >> x[2:0] (MSB is leftmost pixel).
- States:
  - IDLE: on accept:
    - op 0..2 with y<192 -> RD.
    - op 0..2 with y>=192 -> DROP.
    - op 3 -> CLR.
  - DROP: one cycle; done=1; no memory access; -> IDLE.
  - RD:
    - mem_addr held, mem_wren=0, for RD_LAT cycles (counter).
    - On the last cycle, capture mem_q into rdata; -> WR.
  - WR:
    - mem_wren=1 for exactly one cycle; same mem_addr.
    - mem_data = rdata|M (PLOT), rdata&~M (UNPLOT), rdata^M (XOR).
    - done=1 in this cycle; -> IDLE.
  - CLR:
    - 13-bit counter c from 0 to 6911; one write per cycle; mem_wren=1 every cycle.
    - c<6144: mem_addr={BASE_HI,c}, mem_data=0x00.
    - c>=6144: mem_addr={BASE_HI,c}, i.e. 0x5800..0x5AFF, mem_data=latched attr.
    - On c=6911: done=1; -> IDLE.
- Latency:
  - Pixel ops: accept at edge N; mem_wren at cycle N+1+RD_LAT; cmd_ready high again at cycle N+2+RD_LAT.
  - CLEAR: 6912 consecutive write cycles, then ready.
- No back-to-back acceptance: cmd_ready is low during the cycle of the final write/done. Acceptance resumes the following cycle.
- mem_wren is 0 in IDLE, DROP, and RD.
- mem_addr/mem_data hold their last values in IDLE (no glitching).
- done is never asserted together with cmd_ready.
- Reset mid-CLEAR or mid-RMW: operation is abandoned immediately, with no further writes and no done pulse. The memory is left partially written, which is acceptable.
- cmd_valid held high while busy is ignored until IDLE; no command is lost or duplicated.

Test Plan:
- Memory model returns 0x00. PLOT x=0,y=0 -> single write, mem_addr=0x4000, mem_data=0x80, write exactly RD_LAT+1 cycles after accept; done pulses in the write cycle.
- Memory holds 0x10 at 0x57FF. PLOT x=255,y=191 -> write 0x57FF data 0x11. XOR at the same point -> write 0x10.
- Memory holds 0xFF at 0x4121. UNPLOT x=8,y=9 -> write 0x4121 data 0x7F. PLOT x=15,y=9 on 0x00 -> data 0x01.
- CLEAR attr=0x38 -> 6912 consecutive wren cycles: 0x4000..0x57FF written 0x00, 0x5800..0x5AFF written 0x38, no gaps; done once at 0x5AFF; cmd_ready high the next cycle.
- PLOT y=192 -> no mem_wren; done pulses one cycle after accept; cmd_ready returns the cycle after.
- reset_n low at CLEAR count 100 -> outputs reach reset values immediately; no writes after; no done. A PLOT issued after release completes normally. cmd_valid held high through a busy period -> exactly one acceptance per command.

Source files
------------

// File: rtl/fb_writer.sv
// rtl/fb_writer.sv - ZX-layout framebuffer write engine (plot/unplot/xor/clear via read-modify-write)
module fb_writer #(
    parameter int         RD_LAT  = 2,
    parameter logic [2:0] BASE_HI = 3'b010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [7:0]  cmd_attr,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_q,
    output logic [7:0]  mem_data,
    output logic        mem_wren,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  OP_PLOT    = 2'd0;
    localparam logic [1:0]  OP_UNPLOT  = 2'd1;
    localparam logic [1:0]  OP_CLEAR   = 2'd3;
    localparam logic [12:0] CLR_LAST   = 13'd6911;
    localparam logic [12:0] ATTR_START = 13'd6144;
    localparam logic [2:0]  RD_LAST    = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DROP,
        S_RD,
        S_WR,
        S_CLR
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [7:0]  mask_q;
    logic [7:0]  attr_q;
    logic [2:0]  rd_cnt;
    logic [12:0] clr_cnt;
    logic [12:0] clr_nx;
    logic [12:0] a13;
    logic        accept;
    logic        y_ok;
    logic        rd_last;
    logic        clr_last;

    // Spectrum bitmap interleave: third, pixel line within cell, cell row, column byte
    assign a13      = {cmd_y[7:6], cmd_y[2:0], cmd_y[5:3], cmd_x[7:3]};
    assign y_ok     = cmd_y < 8'd192;
    assign accept   = cmd_valid && cmd_ready;
    assign rd_last  = rd_cnt == RD_LAST;
    assign clr_last = clr_cnt == CLR_LAST;
    assign clr_nx   = clr_cnt + 13'd1;
    assign busy     = !cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        mem_wren  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_CLEAR) begin
                        state_nx = S_CLR;
                    end else if (y_ok) begin
                        state_nx = S_RD;
                    end else begin
                        state_nx = S_DROP;
                    end
                end
            end
            S_DROP: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_RD: begin
                if (rd_last) begin
                    state_nx = S_WR;
                end
            end
            S_WR: begin
                mem_wren = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_CLR: begin
                mem_wren = 1'b1;
                if (clr_last) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address/data are registered so they stay put in IDLE between commands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_PLOT;
            mask_q   <= 8'h00;
            attr_q   <= 8'h00;
            rd_cnt   <= 3'd0;
            clr_cnt  <= 13'd0;
            mem_addr <= 16'h0000;
            mem_data <= 8'h00;
        end else if (accept) begin
            op_q    <= cmd_op;
            mask_q  <= 8'h80 >> cmd_x[2:0];
            attr_q  <= cmd_attr;
            rd_cnt  <= 3'd0;
            clr_cnt <= 13'd0;
            if (cmd_op == OP_CLEAR) begin
                mem_addr <= {BASE_HI, 13'd0};
                mem_data <= 8'h00;
            end else if (y_ok) begin
                mem_addr <= {BASE_HI, a13};
            end
        end else begin
            case (state)
                S_RD: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    if (rd_last) begin
                        case (op_q)
                            OP_PLOT:   mem_data <= mem_q | mask_q;
                            OP_UNPLOT: mem_data <= mem_q & ~mask_q;
                            default:   mem_data <= mem_q ^ mask_q;
                        endcase
                    end
                end
                S_CLR: begin
                    if (!clr_last) begin
                        clr_cnt  <= clr_nx;
                        mem_addr <= {BASE_HI, clr_nx};
                        mem_data <= (clr_nx >= ATTR_START) ? attr_q : 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
